// File: rtl/pwm_fade_ctrl.sv
// Triangle-fade sequencer feeding a PWM datapath: ramps duty up, dwells, ramps down, dwells.
// Define PWM_FADE_LOOP_EN to restart the fade endlessly (until stop) instead of returning to idle.
module pwm_fade_ctrl #(
  parameter int CNT_W  = 32,
  parameter int HOLD_W = 16
) (
  input  logic              i_sysclk,
  input  logic              i_resetn,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [CNT_W-1:0]  i_freq_cnt,
  input  logic [CNT_W-1:0]  i_step_cnt,
  input  logic [HOLD_W-1:0] i_hold_cnt,
  output logic              o_enable,
  output logic [CNT_W-1:0]  o_freq_cnt,
  output logic [CNT_W-1:0]  o_duty_cnt,
  output logic              o_period_tick,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RAMP_UP,
    S_HOLD_HI,
    S_RAMP_DN,
    S_HOLD_LO
  } state_t;

  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   freq_q, freq_d;
  logic [CNT_W-1:0]   step_q, step_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [CNT_W-1:0]   duty_q, duty_d;
  logic [CNT_W-1:0]   per_q, per_d;
  logic [HOLD_W-1:0]  hcnt_q, hcnt_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               busy;
  logic               tick;
  logic               hold_last;
  logic               seq_end;
  logic [CNT_W:0]     up_sum;
  logic [HOLD_W-1:0]  hcnt_inc;

  assign busy      = (state_q != S_IDLE);
  // freq_q is never zero while busy, so freq_q-1 cannot wrap here.
  assign tick      = busy && (per_q == (freq_q - CNT_ONE));
  assign hcnt_inc  = hcnt_q + HOLD_ONE;
  assign hold_last = (hcnt_inc == hold_q);
  // One extra bit so duty+step cannot overflow before the saturation compare.
  assign up_sum    = {1'b0, duty_q} + {1'b0, step_q};

  // NOTE: every variable driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    freq_d  = freq_q;
    step_d  = step_q;
    hold_d  = hold_q;
    duty_d  = duty_q;
    per_d   = per_q;
    hcnt_d  = hcnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    seq_end = 1'b0;

    if (state_q == S_IDLE) begin
      if (i_start && !i_stop) begin
        if ((i_freq_cnt != '0) && (i_step_cnt != '0)) begin
          freq_d  = i_freq_cnt;
          step_d  = i_step_cnt;
          hold_d  = i_hold_cnt;
          duty_d  = '0;
          per_d   = '0;
          hcnt_d  = '0;
          state_d = S_RAMP_UP;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (i_stop) begin
      state_d = S_IDLE;
      duty_d  = '0;
      per_d   = '0;
      hcnt_d  = '0;
    end else begin
      per_d = tick ? '0 : (per_q + CNT_ONE);
      if (tick) begin
        unique case (state_q)
          S_RAMP_UP: begin
            if (up_sum >= {1'b0, freq_q}) begin
              duty_d  = freq_q;
              state_d = (hold_q == '0) ? S_RAMP_DN : S_HOLD_HI;
            end else begin
              duty_d = up_sum[CNT_W-1:0];
            end
          end
          S_HOLD_HI: begin
            if (hold_last) begin
              hcnt_d  = '0;
              state_d = S_RAMP_DN;
            end else begin
              hcnt_d = hcnt_inc;
            end
          end
          S_RAMP_DN: begin
            if (duty_q <= step_q) begin
              duty_d = '0;
              if (hold_q == '0) seq_end = 1'b1;
              else              state_d = S_HOLD_LO;
            end else begin
              duty_d = duty_q - step_q;
            end
          end
          S_HOLD_LO: begin
            if (hold_last) begin
              hcnt_d  = '0;
              seq_end = 1'b1;
            end else begin
              hcnt_d = hcnt_inc;
            end
          end
          default: state_d = S_IDLE;
        endcase
      end

      if (seq_end) begin
        done_d = 1'b1;
        duty_d = '0;
`ifdef PWM_FADE_LOOP_EN
        state_d = S_RAMP_UP;
`else
        state_d = S_IDLE;
        per_d   = '0;
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_sysclk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q <= S_IDLE;
      freq_q  <= '0;
      step_q  <= '0;
      hold_q  <= '0;
      duty_q  <= '0;
      per_q   <= '0;
      hcnt_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      freq_q  <= freq_d;
      step_q  <= step_d;
      hold_q  <= hold_d;
      duty_q  <= duty_d;
      per_q   <= per_d;
      hcnt_q  <= hcnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign o_enable      = busy;
  assign o_busy        = busy;
  assign o_freq_cnt    = freq_q;
  assign o_duty_cnt    = duty_q;
  assign o_period_tick = tick;
  assign o_done        = done_q;
  assign o_cfg_err     = err_q;

endmodule
